// File: rtl/seq_addsub_nbit.sv
// Sequential N-bit adder/subtractor.
// Operands are captured on the accepting edge and processed K bits per
// cycle, least-significant chunk first. Sum/Cout/Ovf change only when the
// final chunk completes, so partial results never reach the outputs.
module seq_addsub_nbit #(
  parameter int N = 4,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         mode,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int CHUNKS = N / K;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // acc holds operand A; as its low chunk is consumed the result chunk is
  // shifted in at the top, so after the last chunk it holds the full result.
  logic [N-1:0]  acc;
  logic [N-1:0]  bop;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [K:0]    chunk;
  logic [N-1:0]  acc_shift;
  logic          ovf_calc;
  logic          last_chunk;

  // K-bit chunk adder on the unprocessed low bits plus running carry
  always_comb begin
    chunk = {1'b0, acc[K-1:0]} + {1'b0, bop[K-1:0]} + {{K{1'b0}}, carry};
  end

  // Result shift: new chunk enters at the top, consumed bits leave the bottom
  if (N == K) begin : g_single
    assign acc_shift = chunk[K-1:0];
  end else begin : g_multi
    assign acc_shift = {chunk[K-1:0], acc[N-1:K]};
  end

  // On the last chunk the top bit of acc/bop is operand bit N-1; the carry
  // into that bit is a ^ b ^ sum there, and overflow is that XOR carry out.
  assign ovf_calc   = acc[K-1] ^ bop[K-1] ^ chunk[K-1] ^ chunk[K];
  assign last_chunk = (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs decoded from state
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture (B inverted and carry flipped for subtract) and chunk processing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      bop   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= A;
            bop   <= B ^ {N{mode}};
            carry <= Cin ^ mode;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_shift;
          bop   <= bop >> K;
          carry <= chunk[K];
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Visible results load only when the final chunk completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum  <= '0;
      Cout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (state == BUSY && last_chunk) begin
      Sum  <= acc_shift;
      Cout <= chunk[K];
      Ovf  <= ovf_calc;
    end
  end

endmodule

// File: tb/tb_seq_addsub_nbit.sv
// Bench for seq_addsub_nbit: four configurations (N=4 with K=1,2,4 and
// N=8 with K=4) run side by side. Stimulus pushes expected results into a
// per-configuration queue; a monitor pops and compares on every done pulse.
module tb_seq_addsub_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int N  = (gi == 3) ? 8 : 4;
    localparam int K  = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int CH = N / K;

    typedef struct {
      logic [N+1:0] exp;
      int           e0;
    } exp_t;

    exp_t q[$];

    logic         rst_n;
    logic         start;
    logic         cin;
    logic         mode;
    logic         busy;
    logic         done;
    logic         cout;
    logic         ovf;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;

    int checks = 0;
    int errors = 0;
    bit fin = 1'b0;
    logic [N+1:0] held;

    seq_addsub_nbit #(.N(N), .K(K)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .A    (a),
      .B    (b),
      .Cin  (cin),
      .mode (mode),
      .busy (busy),
      .done (done),
      .Sum  (sum),
      .Cout (cout),
      .Ovf  (ovf)
    );

    // Integer reference: {Cout, Ovf, Sum}
    function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                           input logic mc, input logic mm);
      int ua, ub, sa, sb, ci, u, s;
      logic co, ov;
      logic [N-1:0] sm;
      ua = ma;
      ub = mb;
      sa = $signed(ma);
      sb = $signed(mb);
      ci = mc;
      if (!mm) begin
        u  = ua + ub + ci;
        s  = sa + sb + ci;
        co = (u >= (1 << N));
      end else begin
        u  = ua - ub - ci;
        s  = sa - sb - ci;
        co = (ua >= ub + ci);
      end
      sm = u[N-1:0];
      ov = (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
      return {co, ov, sm};
    endfunction

    task automatic check(input string name, input logic [N+1:0] act, input logic [N+1:0] req);
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL cfg%0d N=%0d K=%0d %s: got %h, required %h", gi, N, K, name, act, req);
      end
    endtask

    task automatic push_exp(input logic [N+1:0] exp);
      exp_t t;
      t.exp = exp;
      t.e0  = cyc;
      q.push_back(t);
    endtask

    // One operation from IDLE; returns at +2 in the IDLE cycle after DONE.
    // Operands are scrambled right after acceptance; glitch also pulses start
    // during BUSY and DONE, which must be ignored.
    task automatic op(input logic [N-1:0] oa, input logic [N-1:0] ob, input logic oc,
                      input logic om, input bit glitch, input logic [N+1:0] exp);
      int n;
      a = oa; b = ob; cin = oc; mode = om; start = 1'b1;
      @(posedge clk); #2;
      push_exp(exp);
      a = ~oa; b = ~ob; cin = ~oc; mode = ~om;
      if (!glitch) start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(posedge clk); #2;
        start = 1'b0;
        n++;
      end
      check("done_within_budget", (N+2)'(n < 40), (N+2)'(1));
      if (glitch) start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    endtask

    // Start an operation, pull reset low between edges mid-BUSY
    task automatic rst_test(input logic [N-1:0] oa, input logic [N-1:0] ob);
      a = oa; b = ob; cin = 1'b0; mode = 1'b0; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      if (CH >= 2) begin
        @(posedge clk); #2;
      end
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {cout, ovf, sum}, '0);
      check("async_reset_flags", (N+2)'({busy, done}), '0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #2;
    endtask

    // Monitor: compares on done, checks hold of outputs otherwise
    initial begin
      exp_t e;
      int lat;
      held = '0;
      forever begin
        @(posedge clk); #1;
        if (rst_n !== 1'b1) begin
          held = '0;
          check("reset_outputs", {cout, ovf, sum}, '0);
          check("reset_flags", (N+2)'({busy, done}), '0);
        end else begin
          check("busy_done_exclusive", (N+2)'(busy & done), '0);
          if (done === 1'b1) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL cfg%0d N=%0d K=%0d unexpected_done: done=1 with no operation pending, required done=0",
                       gi, N, K);
            end else begin
              e   = q.pop_front();
              lat = cyc - e.e0 + 1;
              check("result", {cout, ovf, sum}, e.exp);
              check("latency", (N+2)'(lat), (N+2)'(CH + 1));
              held = e.exp;
              $display("cfg%0d N=%0d K=%0d: cout=%b ovf=%b sum=%h latency=%0d (expected %h)",
                       gi, N, K, cout, ovf, sum, lat, e.exp);
            end
          end else begin
            check("outputs_held", {cout, ovf, sum}, held);
          end
        end
      end
    end

    if (N == 4) begin : g_s4
      initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0;
        #3;
        check("power_up_outputs", {cout, ovf, sum}, '0);
        check("power_up_flags", (N+2)'({busy, done}), '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        // Hand-computed vectors: {Cout, Ovf, Sum}
        op(4'd7, 4'd9, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 4'd0});
        op(4'd7, 4'd1, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 4'd8});
        op(4'd3, 4'd5, 1'b0, 1'b1, 1'b0, {1'b0, 1'b0, 4'd14});
        op(4'd5, 4'd3, 1'b1, 1'b1, 1'b1, {1'b1, 1'b0, 4'd1});
        rst_test(4'd6, 4'd5);
        op(4'd7, 4'd9, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 4'd0});
        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
          for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
              for (int im = 0; im < 2; im++) begin
                op(N'(ia), N'(ib), 1'(ic), 1'(im), ((ia + ib + ic + im) % 5) == 0,
                   model(N'(ia), N'(ib), 1'(ic), 1'(im)));
              end
            end
          end
        end
        check("pending_at_end", (N+2)'(q.size()), '0);
        fin = 1'b1;
      end
    end else begin : g_s8
      initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0;
        #3;
        check("power_up_outputs", {cout, ovf, sum}, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        op(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 8'd44});
        op(8'd100, 8'd200, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 8'd156});
        rst_test(8'd77, 8'd33);
        // start held high for 20 cycles: a new op every 4 cycles
        a = 8'd200; b = 8'd100; cin = 1'b0; mode = 1'b0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
          @(posedge clk); #2;
          if (((k - 1) % 4) == 0) push_exp({1'b1, 1'b0, 8'd44});
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("pending_at_end", (N+2)'(q.size()), '0);
        fin = 1'b1;
      end
    end
  end

  initial begin
    int n;
    int tot_checks;
    int tot_errors;
    n = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    tot_checks = g_cfg[0].checks + g_cfg[1].checks + g_cfg[2].checks + g_cfg[3].checks + 1;
    tot_errors = g_cfg[0].errors + g_cfg[1].errors + g_cfg[2].errors + g_cfg[3].errors;
    if (n >= 60000) begin
      tot_errors++;
      $display("FAIL global_timeout: stimulus not finished after %0d cycles, required completion", n);
    end
    $display("Simulation finished: %0d checks, %0d errors", tot_checks, tot_errors);
    $finish;
  end

endmodule
